phys_reg_free_list: RTL

//  Multi-way circular free list of physical register tags for the rename stage.

---
 rtl/phys_reg_free_list.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/phys_reg_free_list.sv
// Multi-way circular free list of physical register tags for rename.
// Up to WAY tags are granted per cycle (all-or-nothing, compacted onto the
// requesting lanes) and up to WAY stale tags are reclaimed per cycle from ROB
// commit. A commit-side head pointer lets a flush restore the speculative head
// in a single cycle. Pointers carry a wrap bit above the list index.
module phys_reg_free_list #(
    parameter int PRF_ENTRY  = 64,
    parameter int ARCH_ENTRY = 32,
    parameter int WAY        = 2,
    localparam int PRF_WIDTH = $clog2(PRF_ENTRY),
    localparam int DEPTH     = PRF_ENTRY - ARCH_ENTRY,
    localparam int IW        = $clog2(DEPTH),
    localparam int PW        = IW + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WAY-1:0]           alloc_req,
    output logic                     alloc_gnt,
    output logic [WAY*PRF_WIDTH-1:0] alloc_preg,
    input  logic [WAY-1:0]           free_valid,
    input  logic [WAY*PRF_WIDTH-1:0] free_preg,
    input  logic [WAY-1:0]           commit_valid,
    input  logic                     flush,
    output logic [PW-1:0]            free_count
);

    // Advance a wrap-bit pointer by n entries (n <= DEPTH).
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr, input int n);
        int   idx;
        logic wrap;
        idx  = int'(ptr[IW-1:0]) + n;
        wrap = ptr[PW-1];
        if (idx >= DEPTH) begin
            idx  = idx - DEPTH;
            wrap = ~wrap;
        end
        return {wrap, IW'(idx)};
    endfunction

    // List index k entries past a pointer.
    function automatic logic [IW-1:0] ptr_index(input logic [PW-1:0] ptr, input int k);
        int idx;
        idx = int'(ptr[IW-1:0]) + k;
        if (idx >= DEPTH) begin
            idx = idx - DEPTH;
        end
        return IW'(idx);
    endfunction

    // Distance a - b; the wrap bits disambiguate full from empty.
    function automatic logic [PW-1:0] ptr_diff(input logic [PW-1:0] a, input logic [PW-1:0] b);
        int d;
        if (a[PW-1] == b[PW-1]) begin
            d = int'(a[IW-1:0]) - int'(b[IW-1:0]);
        end else begin
            d = DEPTH + int'(a[IW-1:0]) - int'(b[IW-1:0]);
        end
        return PW'(d);
    endfunction

    logic [PRF_WIDTH-1:0] list_reg [DEPTH];
    logic [PW-1:0]        head_reg;
    logic [PW-1:0]        head_next;
    logic [PW-1:0]        tail_reg;
    logic [PW-1:0]        tail_next;
    logic [PW-1:0]        commit_head_reg;
    logic [PW-1:0]        commit_head_next;
    logic [PW-1:0]        free_count_reg;

    logic [PW-1:0]        count;
    logic [PW-1:0]        inflight;
    int                   n_alloc;
    int                   n_commit;
    int                   n_free_kept;
    int                   n_free_applied;
    int                   free_room;
    logic                 overfill;
    logic [WAY-1:0]       free_keep;
    logic [WAY-1:0]       free_wr;
    int                   free_rank [WAY];

    assign count     = ptr_diff(tail_reg, head_reg);
    assign inflight  = ptr_diff(head_reg, commit_head_reg);
    assign n_alloc   = $countones(alloc_req);
    assign n_commit  = $countones(commit_valid);
    assign alloc_gnt = (n_alloc != 0) && (n_alloc <= int'(count)) && !flush;
    assign free_count = free_count_reg;

    // Free slots still writable this cycle; frees beyond this are dropped.
    assign free_room   = DEPTH - int'(count);
    assign n_free_kept = $countones(free_keep);
    assign overfill    = (int'(count) + n_free_kept) > DEPTH;

    // Each alloc lane reads the entry at head plus the number of requesting
    // lanes below it, so granted tags land compacted in lane order.
    for (genvar gi = 0; gi < WAY; gi++) begin : g_alloc_lane
        localparam logic [WAY-1:0] LOWER_MASK = WAY'((1 << gi) - 1);
        assign alloc_preg[gi*PRF_WIDTH +: PRF_WIDTH] =
            list_reg[ptr_index(head_reg, $countones(alloc_req & LOWER_MASK))];
    end

    // Tag 0 is the hard-wired zero mapping and never re-enters the list.
    for (genvar gi = 0; gi < WAY; gi++) begin : g_free_keep
        assign free_keep[gi] = free_valid[gi] && (free_preg[gi*PRF_WIDTH +: PRF_WIDTH] != '0);
    end

    // Kept frees are packed from tail in lane order and clipped to the room left.
    for (genvar gi = 0; gi < WAY; gi++) begin : g_free_lane
        localparam logic [WAY-1:0] LOWER_MASK = WAY'((1 << gi) - 1);
        assign free_rank[gi] = $countones(free_keep & LOWER_MASK);
        assign free_wr[gi]   = free_keep[gi] && (free_rank[gi] < free_room);
    end

    // Pointer next-state: flush rewinds head to the post-commit head.
    always_comb begin
        n_free_applied   = (n_free_kept < free_room) ? n_free_kept :
                           ((free_room > 0) ? free_room : 0);
        commit_head_next = ptr_add(commit_head_reg, n_commit);
        tail_next        = ptr_add(tail_reg, n_free_applied);
        head_next        = head_reg;
        if (flush) begin
            head_next = commit_head_next;
        end else if (alloc_gnt) begin
            head_next = ptr_add(head_reg, n_alloc);
        end
    end

    // List storage, pointers and registered occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                list_reg[i] <= PRF_WIDTH'(ARCH_ENTRY + i);
            end
            head_reg        <= '0;
            commit_head_reg <= '0;
            tail_reg        <= {1'b1, {IW{1'b0}}};
            free_count_reg  <= PW'(DEPTH);
        end else begin
            for (int i = 0; i < WAY; i++) begin
                if (free_wr[i]) begin
                    list_reg[ptr_index(tail_reg, free_rank[i])] <= free_preg[i*PRF_WIDTH +: PRF_WIDTH];
                end
            end
            head_reg        <= head_next;
            commit_head_reg <= commit_head_next;
            tail_reg        <= tail_next;
            free_count_reg  <= ptr_diff(tail_next, head_next);
        end
    end

    // Returning more tags than the list can hold means the ROB lost track of ownership.
    a_no_overfill: assert property (@(posedge clk) disable iff (rst) !overfill);

    // Speculative allocations never run more than a full list ahead of commit.
    a_inflight_bound: assert property (@(posedge clk) disable iff (rst) int'(inflight) <= DEPTH);

endmodule
